// File: rtl/guess_pkg.sv
// Shared types and constants for the four-digit guess entry block.
package guess_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  DIGIT_MAX  = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    OFFER
  } state_e;

  // BCD increment with wrap from DIGIT_MAX back to zero.
  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer, stability counter and single-cycle rising-edge press pulse.
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized level matches the accepted level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/guess_entry.sv
// Four-digit BCD guess entry: debounced buttons edit digits, submit offers a duplicate-free guess.
module guess_entry
  import guess_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [3:0]  btn_raw,
  input  logic        submit_raw,
  input  logic        guess_ready,
  output logic        guess_valid,
  output logic [15:0] guess,
  output logic [3:0]  dup_mask,
  output logic        dup_err
);

  logic [NUM_DIGITS-1:0]      btn_press;
  logic                       submit_press;
  state_e                     state_q;
  logic [NUM_DIGITS-1:0][3:0] digits_q;
  logic                       guess_valid_q;
  logic                       dup_err_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_btn
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn_raw[i]),
      .press_o(btn_press[i])
    );
  end

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_submit (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (submit_raw),
    .press_o(submit_press)
  );

  always_comb begin
    dup_mask = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (i != j && digits_q[i] == digits_q[j]) dup_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      digits_q      <= '0;
      guess_valid_q <= 1'b0;
      dup_err_q     <= 1'b0;
    end else begin
      dup_err_q <= 1'b0;
      if (!enable) begin
        // Leaving the game abandons any offer without a handshake.
        state_q       <= IDLE;
        digits_q      <= '0;
        guess_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            digits_q      <= '0;
            guess_valid_q <= 1'b0;
            state_q       <= EDIT;
          end
          EDIT: begin
            // Digit presses take priority; a coincident submit is dropped.
            if (|btn_press) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (btn_press[i]) digits_q[i] <= digit_inc(digits_q[i]);
              end
            end else if (submit_press) begin
              if (dup_mask == '0) begin
                state_q       <= OFFER;
                guess_valid_q <= 1'b1;
              end else begin
                dup_err_q <= 1'b1;
              end
            end
          end
          OFFER: begin
            if (guess_ready) begin
              state_q       <= EDIT;
              guess_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q       <= IDLE;
            guess_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign guess       = digits_q;
  assign guess_valid = guess_valid_q;
  assign dup_err     = dup_err_q;

endmodule

// File: tb/tb_guess_entry.sv
// Randomized scoreboard bench for guess_entry with a digit-array reference model.
module tb_guess_entry;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  btn_raw = 4'b0;
  logic        submit_raw = 1'b0;
  logic        guess_ready = 1'b0;
  logic        guess_valid;
  logic [15:0] guess;
  logic [3:0]  dup_mask;
  logic        dup_err;

  guess_entry #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .btn_raw    (btn_raw),
    .submit_raw (submit_raw),
    .guess_ready(guess_ready),
    .guess_valid(guess_valid),
    .guess      (guess),
    .dup_mask   (dup_mask),
    .dup_err    (dup_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: digit values and game mode (0 idle, 1 edit, 2 offer).
  int mdig[4];
  int mode = 0;

  logic [15:0] xfer_q[$];
  logic [3:0]  err_q[$];
  logic        prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] model_guess();
    return 16'(mdig[3] * 4096 + mdig[2] * 256 + mdig[1] * 16 + mdig[0]);
  endfunction

  // A digit is duplicated when its value occurs more than once.
  function automatic logic [3:0] model_dup();
    int cnt[10];
    logic [3:0] m;
    m = '0;
    for (int v = 0; v < 10; v++) cnt[v] = 0;
    for (int i = 0; i < 4; i++) cnt[mdig[i]]++;
    for (int i = 0; i < 4; i++) m[i] = (cnt[mdig[i]] > 1);
    return m;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) mdig[i] = 0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer or an error pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (guess_valid && guess_ready) begin
        if (xfer_q.size() == 0) check("xfer_unexpected_qsize", 32'(xfer_q.size()), 1);
        else check("xfer_guess", guess, xfer_q.pop_front());
      end
      if (dup_err) begin
        check("dup_err_width", prev_err, 0);
        if (err_q.size() == 0) check("dup_err_unexpected_qsize", 32'(err_q.size()), 1);
        else check("dup_err_mask", dup_mask, err_q.pop_front());
      end
      prev_err = dup_err;
    end
  end

  task automatic press(input logic [3:0] mask, input logic sub);
    if (mode == 1) begin
      if (mask != 0) begin
        for (int i = 0; i < 4; i++) if (mask[i]) mdig[i] = (mdig[i] + 1) % 10;
      end else if (sub) begin
        if (model_dup() != 0) err_q.push_back(model_dup());
        else mode = 2;
      end
    end
    btn_raw = mask;
    submit_raw = sub;
    tick(8);
    btn_raw = 4'b0;
    submit_raw = 1'b0;
    tick(8);
    check("guess", guess, model_guess());
    check("guess_valid", guess_valid, 32'(mode == 2));
    check("dup_mask", dup_mask, model_dup());
  endtask

  task automatic accept();
    guess_ready = 1'b1;
    if (mode == 2) begin
      xfer_q.push_back(model_guess());
      mode = 1;
    end
    tick(1);
    guess_ready = 1'b0;
    tick(1);
    check("accept_valid", guess_valid, 32'(mode == 2));
    check("accept_guess", guess, model_guess());
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    tick(1);
    mode = 0;
    clear_model();
    check("drop_guess", guess, 0);
    check("drop_valid", guess_valid, 0);
    enable = 1'b1;
    tick(1);
    mode = 1;
  endtask

  task automatic set_digits(input int t3, input int t2, input int t1, input int t0);
    int t[4];
    logic [3:0] mask;
    t = '{t0, t1, t2, t3};
    for (int n = 0; n < 10; n++) begin
      mask = '0;
      for (int i = 0; i < 4; i++) if (mdig[i] != t[i]) mask[i] = 1'b1;
      if (mask == 0) break;
      press(mask, 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    clear_model();
    #12;
    check("rst_guess", guess, 0);
    check("rst_valid", guess_valid, 0);
    check("rst_dup_err", dup_err, 0);
    check("rst_dup_mask", dup_mask, 4'b1111);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    enable = 1'b1;
    tick(1);
    mode = 1;

    // Press latency and no auto-repeat while held.
    btn_raw = 4'b0001;
    tick(6);
    check("latency_early", guess, 0);
    tick(1);
    check("latency_on_time", guess, 16'h0001);
    tick(3);
    check("held_no_repeat", guess, 16'h0001);
    btn_raw = 4'b0;
    tick(8);
    mdig[0] = 1;
    check("after_release", guess, model_guess());

    // Ten presses of digit 2 wrap back to zero.
    for (int k = 0; k < 10; k++) press(4'b0100, 1'b0);
    check("wrap_digit2", guess[11:8], 0);

    // Bouncing input never settles long enough.
    for (int k = 0; k < 10; k++) begin
      btn_raw[0] = ~btn_raw[0];
      tick(2);
    end
    btn_raw = 4'b0;
    tick(8);
    check("bounce_ignored", guess, model_guess());

    // Duplicate rejection.
    set_digits(1, 2, 1, 3);
    check("dup_pattern", dup_mask, 4'b1010);
    press(4'b0000, 1'b1);
    check("dup_err_consumed", 32'(err_q.size()), 0);

    // Simultaneous digit and submit: submit dropped.
    set_digits(4, 3, 2, 1);
    press(4'b0001, 1'b1);
    set_digits(4, 3, 2, 1);

    // Offer held until ready, presses discarded while offering.
    press(4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("offer_valid_hold", guess_valid, 1);
      check("offer_guess_hold", guess, 16'h4321);
    end
    press(4'b0010, 1'b0);
    accept();
    check("post_xfer_guess", guess, 16'h4321);

    // Enable dropped mid-offer.
    press(4'b0000, 1'b1);
    drop_enable();
    accept();

    // Reset asserted mid-debounce.
    set_digits(0, 0, 5, 0);
    btn_raw = 4'b0010;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("async_rst_guess", guess, 0);
    check("async_rst_valid", guess_valid, 0);
    btn_raw = 4'b0;
    tick(2);
    rst_n = 1'b1;
    clear_model();
    tick(12);
    mode = 1;
    check("rst_mid_debounce_guess", guess, 0);

    // Reset asserted mid-offer: no transfer afterwards.
    set_digits(7, 8, 9, 0);
    press(4'b0000, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_offer_valid", guess_valid, 0);
    tick(2);
    rst_n = 1'b1;
    clear_model();
    guess_ready = 1'b1;
    tick(3);
    guess_ready = 1'b0;
    mode = 1;
    check("rst_offer_no_xfer", guess_valid, 0);

    // Button held through reset release yields one press.
    btn_raw = 4'b1000;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("held_through_reset", guess, 16'h1000);
    btn_raw = 4'b0;
    tick(8);
    mdig[3] = 1;
    check("held_through_reset_once", guess, model_guess());

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) press(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else if (r <= 6) press(4'b0000, 1'b1);
      else if (r <= 8) accept();
      else drop_enable();
    end

    tick(4);
    check("xfer_q_empty", 32'(xfer_q.size()), 0);
    check("err_q_empty", 32'(err_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
